// File: rtl/mod_counter_ud_pkg.sv
// Shared constants and helpers for the up/down modulo counter.
package mod_counter_ud_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Terminal value when counting up; each instance derives its own TERM_UP from this.
    function automatic int term_up(input int modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/mod_counter_ud_tick_prescaler.sv
// Divides the enable by PRESCALE: STEP fires on every PRESCALE-th enabled cycle.
module mod_counter_ud_tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic CLoK,
    input  logic Reset,
    input  logic CLR,
    input  logic EN,
    output logic STEP
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] p_reg;
    logic [PW-1:0] p_next;

    // With PRESCALE=1 the phase register is constant zero, so STEP reduces to EN.
    assign STEP = EN & (p_reg == LAST);

    always_comb begin
        p_next = p_reg;
        if (CLR) begin
            p_next = '0;
        end else if (EN) begin
            p_next = (p_reg == LAST) ? '0 : p_reg + 1'b1;
        end
    end

    always_ff @(posedge CLoK or posedge Reset) begin
        if (Reset) begin
            p_reg <= '0;
        end else begin
            p_reg <= p_next;
        end
    end

endmodule

// File: rtl/mod_counter_ud.sv
// Parametrised up/down modulo counter with wrap/saturate modes, load, clear,
// prescaled enable and cascade outputs.
module mod_counter_ud
    import mod_counter_ud_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input  logic             CLoK,
    input  logic             Reset,
    input  logic             CLR,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             DIR,
    input  logic             SAT_MODE,
    output logic [WIDTH-1:0] CNTR,
    output logic             TC,
    output logic             CARRY,
    output logic             WRAP,
    output logic             SAT
);

    localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(term_up(MODULUS));
    // One extra bit so MODULUS = 2**WIDTH is representable for the load clamp.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] cntr_reg;
    logic [WIDTH-1:0] cntr_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             sat_reg;
    logic             sat_next;
    logic             step;
    logic             tc;

    mod_counter_ud_tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .CLoK  (CLoK),
        .Reset (Reset),
        .CLR   (CLR | LOAD),
        .EN    (EN),
        .STEP  (step)
    );

    always_comb begin
        tc = 1'b0;
        case (DIR)
            DIR_UP:   tc = (cntr_reg == TERM_UP);
            DIR_DOWN: tc = (cntr_reg == '0);
        endcase
    end

    assign TC    = tc;
    assign CARRY = tc & EN & step;
    assign CNTR  = cntr_reg;
    assign WRAP  = wrap_reg;
    assign SAT   = sat_reg;

    always_comb begin
        cntr_next = cntr_reg;
        wrap_next = 1'b0;
        // A held saturation survives only while still at the boundary for the current DIR and mode.
        sat_next  = sat_reg & (SAT_MODE == MODE_SAT) & tc;
        if (CLR) begin
            cntr_next = '0;
            sat_next  = 1'b0;
        end else if (LOAD) begin
            cntr_next = ({1'b0, LOAD_VAL} < MOD_EXT) ? LOAD_VAL : TERM_UP;
            sat_next  = 1'b0;
        end else if (step) begin
            if (tc) begin
                if (SAT_MODE == MODE_WRAP) begin
                    cntr_next = (DIR == DIR_UP) ? '0 : TERM_UP;
                    wrap_next = 1'b1;
                    sat_next  = 1'b0;
                end else begin
                    sat_next  = 1'b1;
                end
            end else begin
                cntr_next = (DIR == DIR_UP) ? cntr_reg + 1'b1 : cntr_reg - 1'b1;
                sat_next  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLoK or posedge Reset) begin
        if (Reset) begin
            cntr_reg <= '0;
            wrap_reg <= 1'b0;
            sat_reg  <= 1'b0;
        end else begin
            cntr_reg <= cntr_next;
            wrap_reg <= wrap_next;
            sat_reg  <= sat_next;
        end
    end

endmodule

// File: tb/tb_mod_counter_ud.sv
// Directed bench: vector table for a mod-10 counter plus prescaler and async-reset sequences.
module tb_mod_counter_ud;

    typedef struct {
        logic       clr;
        logic       load;
        logic [3:0] lval;
        logic       en;
        logic       dir;
        logic       sm;
        int         cntr;
        logic       tc;
        logic       carry;
        logic       wrap;
        logic       sat;
    } vec_t;

    logic       clk;
    logic       rst;

    logic       clr, load, en, dir, sm;
    logic [3:0] lval;
    logic [3:0] cntr;
    logic       tc, carry, wrap, sat;

    logic       p_clr, p_load, p_en, p_dir, p_sm;
    logic [3:0] p_lval;
    logic [3:0] p_cntr;
    logic       p_tc, p_carry, p_wrap, p_sat;

    int checks = 0;
    int errors = 0;

    vec_t vecs[30];
    int   pseq_en[11]  = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    int   pseq_exp[11] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};

    mod_counter_ud #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut (
        .CLoK     (clk),
        .Reset    (rst),
        .CLR      (clr),
        .EN       (en),
        .LOAD     (load),
        .LOAD_VAL (lval),
        .DIR      (dir),
        .SAT_MODE (sm),
        .CNTR     (cntr),
        .TC       (tc),
        .CARRY    (carry),
        .WRAP     (wrap),
        .SAT      (sat)
    );

    mod_counter_ud #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_p (
        .CLoK     (clk),
        .Reset    (rst),
        .CLR      (p_clr),
        .EN       (p_en),
        .LOAD     (p_load),
        .LOAD_VAL (p_lval),
        .DIR      (p_dir),
        .SAT_MODE (p_sm),
        .CNTR     (p_cntr),
        .TC       (p_tc),
        .CARRY    (p_carry),
        .WRAP     (p_wrap),
        .SAT      (p_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic l, input logic [3:0] lv,
                                input logic e, input logic d, input logic s,
                                input int q, input logic t, input logic ca,
                                input logic w, input logic sa);
        vec_t v;
        v.clr = c; v.load = l; v.lval = lv; v.en = e; v.dir = d; v.sm = s;
        v.cntr = q; v.tc = t; v.carry = ca; v.wrap = w; v.sat = sa;
        return v;
    endfunction

    initial begin
        // Up count in wrap mode through 9 -> 0
        for (int i = 0; i < 8; i++) vecs[i] = mk(0, 0, 0, 1, 0, 0, i + 1, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0,  1, 0, 0, 9, 1, 1, 0, 0);
        vecs[9]  = mk(0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0);
        vecs[10] = mk(0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 0,  1, 0, 0, 2, 0, 0, 0, 0);
        // Down count through 0 -> 9
        vecs[12] = mk(0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0);
        vecs[13] = mk(0, 0, 0,  1, 1, 0, 0, 1, 1, 0, 0);
        vecs[14] = mk(0, 0, 0,  1, 1, 0, 9, 0, 0, 1, 0);
        vecs[15] = mk(0, 0, 0,  1, 1, 0, 8, 0, 0, 0, 0);
        vecs[16] = mk(0, 0, 0,  1, 1, 0, 7, 0, 0, 0, 0);
        // Load beats step, then saturate at the top
        vecs[17] = mk(0, 1, 8,  1, 1, 1, 8, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 0,  1, 0, 1, 9, 1, 1, 0, 0);
        vecs[19] = mk(0, 0, 0,  1, 0, 1, 9, 1, 1, 0, 1);
        vecs[20] = mk(0, 0, 0,  1, 0, 1, 9, 1, 1, 0, 1);
        vecs[21] = mk(0, 0, 0,  1, 1, 1, 8, 0, 0, 0, 0);
        vecs[22] = mk(0, 0, 0,  0, 1, 1, 8, 0, 0, 0, 0);
        // Load clamp, clear beats load
        vecs[23] = mk(0, 1, 13, 0, 1, 1, 9, 0, 0, 0, 0);
        vecs[24] = mk(1, 1, 13, 0, 1, 1, 0, 1, 0, 0, 0);
        // Saturate at bottom, leave saturate mode, wrap down
        vecs[25] = mk(0, 0, 0,  1, 1, 1, 0, 1, 1, 0, 1);
        vecs[26] = mk(0, 0, 0,  0, 1, 0, 0, 1, 0, 0, 0);
        vecs[27] = mk(0, 0, 0,  1, 1, 0, 9, 0, 0, 1, 0);
        vecs[28] = mk(0, 0, 0,  0, 0, 0, 9, 1, 0, 0, 0);
        vecs[29] = mk(0, 1, 5,  0, 0, 0, 5, 0, 0, 0, 0);

        rst = 1'b1;
        clr = 0; load = 0; lval = 0; en = 0; dir = 0; sm = 0;
        p_clr = 0; p_load = 0; p_lval = 0; p_en = 0; p_dir = 0; p_sm = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset cntr", 32'(cntr), 0);
        check("reset wrap", 32'(wrap), 0);
        check("reset sat", 32'(sat), 0);
        check("reset p_cntr", 32'(p_cntr), 0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            clr = vecs[i].clr; load = vecs[i].load; lval = vecs[i].lval;
            en = vecs[i].en; dir = vecs[i].dir; sm = vecs[i].sm;
            @(posedge clk);
            #1;
            $display("vec %0d: clr=%0d load=%0d lval=%0d en=%0d dir=%0d sm=%0d -> cntr=%0d tc=%0d carry=%0d wrap=%0d sat=%0d",
                     i, clr, load, lval, en, dir, sm, cntr, tc, carry, wrap, sat);
            check($sformatf("v%0d cntr", i), 32'(cntr), 32'(vecs[i].cntr));
            check($sformatf("v%0d tc", i), 32'(tc), 32'(vecs[i].tc));
            check($sformatf("v%0d carry", i), 32'(carry), 32'(vecs[i].carry));
            check($sformatf("v%0d wrap", i), 32'(wrap), 32'(vecs[i].wrap));
            check($sformatf("v%0d sat", i), 32'(sat), 32'(vecs[i].sat));
        end

        @(negedge clk);
        clr = 0; load = 0; en = 0;

        // Prescale-by-3 with a two-cycle enable gap
        for (int i = 0; i < 11; i++) begin
            @(negedge clk) p_en = logic'(pseq_en[i]);
            @(posedge clk);
            #1;
            $display("pre %0d: en=%0d -> p_cntr=%0d", i, p_en, p_cntr);
            check($sformatf("pre%0d p_cntr", i), 32'(p_cntr), 32'(pseq_exp[i]));
        end
        check("hold cntr", 32'(cntr), 5);

        // One more enabled cycle leaves the prescaler mid-period before the reset pulse
        @(negedge clk) p_en = 1'b1;
        @(posedge clk);
        #1;
        check("pre mid p_cntr", 32'(p_cntr), 3);
        #2 rst = 1'b1;
        #1;
        $display("async reset: cntr=%0d wrap=%0d sat=%0d p_cntr=%0d", cntr, wrap, sat, p_cntr);
        check("async cntr", 32'(cntr), 0);
        check("async wrap", 32'(wrap), 0);
        check("async sat", 32'(sat), 0);
        check("async p_cntr", 32'(p_cntr), 0);

        @(negedge clk);
        rst = 1'b0; en = 1'b1; dir = 1'b0; sm = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            $display("resume %0d: cntr=%0d p_cntr=%0d", k, cntr, p_cntr);
            check($sformatf("resume%0d cntr", k), 32'(cntr), 32'(k));
            check($sformatf("resume%0d p_cntr", k), 32'(p_cntr), (k == 3) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_counter_ud.md
Name: mod_counter_ud

Overview:
- Parametrised successor to the team's free-running 4-bit counter.
- Configurable width and modulus; up/down direction; wrap or saturate mode.
- Synchronous clear and parallel load; clock-enable with a built-in prescaler.
- Terminal-count and wrap outputs so instances can be cascaded, e.g. digit counters feeding display/timer logic.

Parameters:
WIDTH, 4, counter bit width (>=1)
MODULUS, 16, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
PRESCALE, 1, enabled cycles per count step; 1 = step on every enabled cycle

Ports:
CLoK  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-high reset
CLR  input  1  synchronous clear of counter and prescaler
EN  input  1  count enable; low freezes counter and prescaler
LOAD  input  1  synchronous parallel load
LOAD_VAL  input  WIDTH  value loaded when LOAD=1
DIR  input  1  0 = count up, 1 = count down
SAT_MODE  input  1  0 = wrap at boundary, 1 = saturate (hold) at boundary
CNTR  output  WIDTH  current count, registered
TC  output  1  combinational; 1 when CNTR is at the terminal value for DIR (MODULUS-1 up, 0 down)
CARRY  output  1  combinational; TC & EN & step, for cascading the next stage's EN
WRAP  output  1  registered one-cycle pulse, cycle after a wrap occurred
SAT  output  1  registered level; 1 while held at a boundary in saturate mode

Behaviour:
- Reset=1 (async): CNTR=0, prescaler=0, WRAP=0, SAT=0, held until Reset deasserts.
- Priority per rising edge: CLR > LOAD > count step > hold.
- CLR: CNTR=0, prescaler=0, WRAP=0, SAT=0.
- LOAD:
  - CNTR = LOAD_VAL if LOAD_VAL < MODULUS, else MODULUS-1 (clamp).
  - prescaler=0, WRAP=0, SAT=0.
- Prescaler (internal): p counts 0..PRESCALE-1 while EN=1.
  - step = EN & (p == PRESCALE-1).
  - p wraps to 0 on step and holds while EN=0.
  - PRESCALE=1: step = EN.
- Count step, up (DIR=0):
  - CNTR < MODULUS-1: CNTR+1.
  - CNTR == MODULUS-1, wrap mode: CNTR=0, WRAP=1 next cycle.
  - CNTR == MODULUS-1, saturate mode: hold, SAT=1.
- Count step, down (DIR=1):
  - CNTR > 0: CNTR-1.
  - CNTR == 0, wrap mode: CNTR=MODULUS-1, WRAP=1.
  - CNTR == 0, saturate mode: hold, SAT=1.
- SAT clears on any step that moves CNTR, on DIR change away from the boundary, on CLR/LOAD, or on leaving saturate mode.
- WRAP is 0 in every cycle not immediately following a wrap step.
- DIR or SAT_MODE changes take effect on the next step; no pipeline latency.
- Arithmetic is WIDTH bits, modulo MODULUS. When MODULUS = 2**WIDTH, natural overflow equals wrap.
- Latency: CNTR updates one edge after the step condition. TC/CARRY are combinational from registered CNTR and inputs.

Decomposition:
- Shared package/header holds constants: DIR_UP=0, DIR_DOWN=1, MODE_WRAP=0, MODE_SAT=1.
- Also in the package: localparam TERM_UP = MODULUS-1, derived per instance.
- One sub-module: tick_prescaler.
  - Parameter PRESCALE.
  - Ports: CLoK, Reset, CLR (ORed with LOAD by parent), EN; output STEP.
- Parent holds the count/boundary/flag logic.

Test Plan:
- WIDTH=4, MODULUS=10, PRESCALE=1, DIR=0, wrap, EN=1 for 12 cycles from reset -> CNTR 0..9, 0, 1; WRAP high exactly the cycle after 9->0; TC high while CNTR=9.
- Same config, DIR=1 from CNTR=2 -> 1, 0, 9, 8; WRAP pulse after 0->9.
- SAT_MODE=1, DIR=0, LOAD_VAL=8 then count -> 8, 9, 9, 9; SAT=1 from the first held cycle. Switch DIR=1 -> 8, SAT=0.
- PRESCALE=3, EN=1 -> CNTR increments every 3rd cycle. EN low mid-period for 2 cycles -> period extends by exactly 2 cycles.
- LOAD_VAL=13 with MODULUS=10 -> CNTR=9. LOAD and CLR asserted together -> CNTR=0.
- Async Reset pulse between clock edges while CNTR=5 -> CNTR=0 immediately, WRAP=0, prescaler restarts; counting resumes on the first edge after release.
